// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and ABI names
// for the integer register file.
package reg_file_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [REG_ADDR_W-1:0] SP_REG   = 5'd2;

  typedef enum logic [REG_ADDR_W-1:0] {
    ABI_ZERO = 5'd0,
    ABI_RA   = 5'd1,
    ABI_SP   = 5'd2,
    ABI_GP   = 5'd3,
    ABI_TP   = 5'd4,
    ABI_A0   = 5'd10,
    ABI_A1   = 5'd11,
    ABI_A2   = 5'd12,
    ABI_A3   = 5'd13,
    ABI_A4   = 5'd14,
    ABI_A5   = 5'd15,
    ABI_A6   = 5'd16,
    ABI_A7   = 5'd17
  } abi_reg_e;

endpackage

// File: rtl/reg_file_cell.sv
// reg_cell: one XLEN-bit architectural register
// with async active-low reset to RST_VAL.
module reg_cell #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold value; load d when enabled.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: x0..x31 integer registers, two
// combinational read ports plus a debug port.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  SP_RESET = '0,
  parameter bit               BYPASS   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       wd,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2,
  output logic [XLEN-1:0]       dbg_data
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_ok;

  assign wr_ok   = we && (rd != ZERO_REG);
  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
    localparam logic [XLEN-1:0] RV =
      (REG_ADDR_W'(i) == SP_REG) ? SP_RESET : '0;
    reg_cell #(
      .W       (XLEN),
      .RST_VAL (RV)
    ) u_cell (
      .CLK (CLK),
      .rst (rst),
      .en  (wr_ok && (rd == REG_ADDR_W'(i))),
      .d   (wd),
      .q   (regs[i])
    );
  end

  function automatic logic [XLEN-1:0] rport(
    input logic [REG_ADDR_W-1:0] a,
    input logic                  fwd
  );
    if (a == ZERO_REG)     return '0;
    if (fwd && (a == rd))  return wd;
    return regs[a];
  endfunction

  logic fwd_en;

  // Read muxes with optional write-data forwarding.
  always_comb begin
    fwd_en   = BYPASS && rst && wr_ok;
    rd1      = rport(rs1, fwd_en);
    rd2      = rport(rs2, fwd_en);
    dbg_data = rport(dbg_addr, fwd_en);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: random and directed checks of
// reg_file, with and without forwarding.
module tb_reg_file;

  localparam logic [31:0] SPR = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  rs1, rs2, rd, dbg_addr;
  logic [31:0] wd;
  logic [31:0] a_rd1, a_rd2, a_dbg;
  logic [31:0] b_rd1, b_rd2, b_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] mem [32];

  always #5 CLK = ~CLK;

  reg_file #(.XLEN(32), .SP_RESET(SPR), .BYPASS(1'b0)) u_a (
    .CLK(CLK), .rst(rst), .we(we), .rs1(rs1), .rs2(rs2),
    .rd(rd), .wd(wd), .dbg_addr(dbg_addr),
    .rd1(a_rd1), .rd2(a_rd2), .dbg_data(a_dbg)
  );

  reg_file #(.XLEN(32), .SP_RESET(SPR), .BYPASS(1'b1)) u_b (
    .CLK(CLK), .rst(rst), .we(we), .rs1(rs1), .rs2(rs2),
    .rd(rd), .wd(wd), .dbg_addr(dbg_addr),
    .rd1(b_rd1), .rd2(b_rd2), .dbg_data(b_dbg)
  );

  // Reference array: reset image or committed write.
  always @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem[2] <= SPR;
    end else if (we && rd != 5'd0) begin
      mem[rd] <= wd;
    end
  end

  function automatic logic [31:0] expect_rd(
    input logic [4:0] a, input bit byp
  );
    if (a == 5'd0) return 32'h0;
    if (byp && rst && we && a == rd) return wd;
    return mem[a];
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Compare every port against the model mid-cycle.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("a_rd1", a_rd1, expect_rd(rs1, 1'b0));
      chk("a_rd2", a_rd2, expect_rd(rs2, 1'b0));
      chk("a_dbg", a_dbg, expect_rd(dbg_addr, 1'b0));
      chk("b_rd1", b_rd1, expect_rd(rs1, 1'b1));
      chk("b_rd2", b_rd2, expect_rd(rs2, 1'b1));
      chk("b_dbg", b_dbg, expect_rd(dbg_addr, 1'b1));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; rd = '0; wd = '0;
    rs1 = '0; rs2 = '0; dbg_addr = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      chk("rst_sweep", a_rd1, (i == 2) ? SPR : 32'h0);
    end
    tick();
    rst = 1'b1;
    rs1 = 5'd0;
    tick();

    // x5 then x31
    we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF; rs1 = 5'd5;
    #1;
    chk("x5_pre_nobyp", a_rd1, 32'h0);
    chk("x5_pre_byp", b_rd1, 32'hDEADBEEF);
    tick();
    rd = 5'd31; wd = 32'h12345678; rs2 = 5'd31;
    #1;
    chk("x5_post", a_rd1, 32'hDEADBEEF);
    chk("x31_pre", a_rd2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("x31_post", a_rd2, 32'h12345678);

    // x0 protection
    we = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF;
    rs1 = 5'd0; rs2 = 5'd0; dbg_addr = 5'd0;
    #1;
    chk("x0_pre_byp", b_rd1, 32'h0);
    tick();
    we = 1'b0; rs2 = 5'd5;
    #1;
    chk("x0_post", a_rd1, 32'h0);
    chk("x0_noside", a_rd2, 32'hDEADBEEF);

    // forwarding on x7
    we = 1'b1; rd = 5'd7; wd = 32'h11;
    tick();
    wd = 32'h22; rs1 = 5'd7; rs2 = 5'd7; dbg_addr = 5'd7;
    #1;
    chk("fwd_rd1", b_rd1, 32'h22);
    chk("fwd_rd2", b_rd2, 32'h22);
    chk("fwd_dbg", b_dbg, 32'h22);
    chk("nofwd_rd1", a_rd1, 32'h11);
    we = 1'b0;
    #1;
    chk("fwd_off", b_rd1, 32'h11);
    tick();

    // async reset mid-cycle, colliding with a write
    #2;
    we = 1'b1; rd = 5'd9; wd = 32'hAAAAAAAA;
    rs1 = 5'd7; rs2 = 5'd2; dbg_addr = 5'd9;
    rst = 1'b0;
    #1;
    chk("async_rst_x7", a_rd1, 32'h0);
    chk("async_rst_sp", b_rd2, SPR);
    chk("async_rst_fwd", b_dbg, 32'h0);
    tick();
    we = 1'b0;
    rst = 1'b1;
    #1;
    chk("collide_x9", a_dbg, 32'h0);
    tick();

    // random regression
    for (int n = 0; n < 1000; n++) begin
      we       = 1'($urandom);
      rd       = 5'($urandom);
      wd       = $urandom;
      rs1      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      rs2      = 5'($urandom);
      dbg_addr = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      tick();
    end
    we = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
